// File: rtl/led_array_arbiter_if.sv
// led_array_arbiter_if: request/pattern bus between LED sources and the arbiter.
interface led_array_arbiter_if;
    logic [7:0] i_base_data;
    logic       i_evt_req;
    logic [7:0] i_evt_data;
    logic [3:0] i_evt_count;
    logic       i_alert_req;
    logic [7:0] i_alert_data;
    logic [7:0] o_led_data;
    logic       o_evt_ack;
    logic       o_evt_done;
    logic       o_busy;
    modport slave (
        input  i_base_data, i_evt_req, i_evt_data, i_evt_count, i_alert_req, i_alert_data,
        output o_led_data, o_evt_ack, o_evt_done, o_busy
    );
    modport master (
        output i_base_data, i_evt_req, i_evt_data, i_evt_count, i_alert_req, i_alert_data,
        input  o_led_data, o_evt_ack, o_evt_done, o_busy
    );
endinterface

// File: rtl/led_array_arbiter.sv
// led_array_arbiter: LED bar arbiter of base pattern, counted event flash and pre-emptive alert blink.
// Optional LED_ARB_BASE_DIM_EN: 25% PWM dimming of the idle base pattern.
module led_array_arbiter #(
    parameter int TICK_DIV       = 50000,
    parameter int HALF_PERIOD_MS = 250
) (
    input logic                clk,
    input logic                rst,
    led_array_arbiter_if.slave bus
);
    localparam int PHASE = TICK_DIV * HALF_PERIOD_MS;
    localparam int CW    = PHASE > 1 ? $clog2(PHASE) : 1;
    typedef enum logic [2:0] {S_IDLE, S_EVT_ON, S_EVT_OFF, S_ALERT_ON, S_ALERT_OFF} state_t;
    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_rem;
    logic [7:0]    r_evt_data, w_led, w_base;
    logic          w_pe, w_ack, w_done;
    assign w_pe = r_cnt == CW'(PHASE - 1);
`ifdef LED_ARB_BASE_DIM_EN
    logic [1:0] r_dim;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_dim <= 2'd0;
        else r_dim <= r_dim + 2'd1;
    assign w_base = r_dim == 2'd0 ? bus.i_base_data : 8'h00;
`else
    assign w_base = bus.i_base_data;
`endif
    always_comb begin
        w_next = r_state;
        w_ack  = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:
                if (bus.i_alert_req) w_next = S_ALERT_ON;
                else if (bus.i_evt_req) begin
                    w_ack  = 1'b1;
                    w_done = bus.i_evt_count == 4'd0;
                    w_next = bus.i_evt_count == 4'd0 ? S_IDLE : S_EVT_ON;
                end
            S_EVT_ON:
                if (bus.i_alert_req) w_next = S_ALERT_ON;
                else if (w_pe) w_next = S_EVT_OFF;
            S_EVT_OFF:
                if (bus.i_alert_req) w_next = S_ALERT_ON;
                else if (w_pe) begin
                    w_done = r_rem == 4'd1;
                    w_next = r_rem == 4'd1 ? S_IDLE : S_EVT_ON;
                end
            S_ALERT_ON:
                if (w_pe) w_next = S_ALERT_OFF;
            S_ALERT_OFF:
                if (w_pe) w_next = bus.i_alert_req ? S_ALERT_ON : S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Outputs are computed from the next state so they change on the transition edge
        w_led = w_next == S_IDLE     ? w_base :
                w_next == S_EVT_ON   ? (w_ack ? bus.i_evt_data : r_evt_data) :
                w_next == S_ALERT_ON ? bus.i_alert_data : 8'h00;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_rem          <= 4'd0;
            r_evt_data     <= 8'h00;
            bus.o_led_data <= 8'h00;
            bus.o_evt_ack  <= 1'b0;
            bus.o_evt_done <= 1'b0;
            bus.o_busy     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + CW'(1);
            if (w_ack) begin
                r_rem      <= bus.i_evt_count;
                r_evt_data <= bus.i_evt_data;
            end else if (w_next == S_ALERT_ON || w_done) r_rem <= 4'd0;
            else if (r_state == S_EVT_OFF && w_next == S_EVT_ON) r_rem <= r_rem - 4'd1;
            bus.o_led_data <= w_led;
            bus.o_evt_ack  <= w_ack;
            bus.o_evt_done <= w_done;
            bus.o_busy     <= w_next != S_IDLE;
        end
    end
endmodule

// File: tb/tb_led_array_arbiter.sv
// tb_led_array_arbiter: directed bench for led_array_arbiter with 12-cycle phases.
module tb_led_array_arbiter;
    localparam int PH = 12;
`ifdef LED_ARB_BASE_DIM_EN
    localparam bit DIM = 1'b1;
`else
    localparam bit DIM = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    led_array_arbiter_if bus();
    led_array_arbiter #(.TICK_DIV(4), .HALF_PERIOD_MS(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.i_base_data = 8'hA5; bus.i_evt_req = 1'b0; bus.i_evt_data = 8'h00;
        bus.i_evt_count = 4'd0; bus.i_alert_req = 1'b0; bus.i_alert_data = 8'h00;
        #1;
        n_chk++;
        if ({bus.o_led_data, bus.o_evt_ack, bus.o_evt_done, bus.o_busy} !== 11'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 000", {bus.o_led_data, bus.o_evt_ack, bus.o_evt_done, bus.o_busy});
        end
        repeat (2) tick();
        n_chk++;
        if (bus.o_led_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_hold_led: got %h expected 00", bus.o_led_data);
        end
        rst = 1'b0;
        tick();
        n_chk++;
        if (bus.o_led_data !== 8'hA5 || bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got led %h busy %b expected A5 0", bus.o_led_data, bus.o_busy);
        end
    endtask

    task automatic test_idle_pattern;
        int on_cnt = 0;
        int bad = 0;
        bus.i_base_data = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.o_led_data === 8'hFF) on_cnt++;
            else if (bus.o_led_data !== 8'h00) bad++;
        end
        n_chk++;
        if (on_cnt != (DIM ? 2 : 8) || bad != 0) begin
            n_fail++; $display("FAIL idle_pattern: got %0d FF cycles (%0d other) expected %0d", on_cnt, bad, DIM ? 2 : 8);
        end
    endtask

    task automatic test_event;
        logic [7:0] exp;
        bus.i_base_data = 8'h3C; bus.i_evt_data = 8'h0F; bus.i_evt_count = 4'd2; bus.i_evt_req = 1'b1;
        tick();
        n_chk++;
        if ({bus.o_evt_ack, bus.o_busy, bus.o_led_data} !== {2'b11, 8'h0F}) begin
            n_fail++; $display("FAIL evt_accept: got ack %b busy %b led %h expected 1 1 0f", bus.o_evt_ack, bus.o_busy, bus.o_led_data);
        end
        bus.i_evt_req = 1'b0; bus.i_evt_data = 8'hFF; bus.i_evt_count = 4'd9;
        for (int k = 1; k < 4 * PH; k++) begin
            tick();
            exp = ((k / PH) % 2 == 0) ? 8'h0F : 8'h00;
            n_chk++;
            if ({bus.o_evt_ack, bus.o_evt_done, bus.o_busy, bus.o_led_data} !== {3'b001, exp}) begin
                n_fail++; $display("FAIL evt_seq[%0d]: got ack %b done %b busy %b led %h expected 0 0 1 %h", k, bus.o_evt_ack, bus.o_evt_done, bus.o_busy, bus.o_led_data, exp);
            end
        end
        tick();
        n_chk++;
        if (bus.o_evt_done !== 1'b1 || bus.o_busy !== 1'b0 || (bus.o_led_data !== 8'h3C && !(DIM && bus.o_led_data === 8'h00))) begin
            n_fail++; $display("FAIL evt_done: got done %b busy %b led %h expected 1 0 3c", bus.o_evt_done, bus.o_busy, bus.o_led_data);
        end
        tick();
        n_chk++;
        if (bus.o_evt_done !== 1'b0) begin
            n_fail++; $display("FAIL evt_done_pulse: got %b expected 0", bus.o_evt_done);
        end
    endtask

    task automatic test_abort_by_alert;
        logic [7:0] exp;
        logic got_done = 1'b0;
        bus.i_base_data = 8'h3C; bus.i_alert_data = 8'h81;
        bus.i_evt_data = 8'h0F; bus.i_evt_count = 4'd3; bus.i_evt_req = 1'b1;
        tick();
        bus.i_evt_req = 1'b0;
        for (int k = 1; k < 5; k++) begin
            tick();
            got_done |= bus.o_evt_done;
            n_chk++;
            if (bus.o_led_data !== 8'h0F) begin
                n_fail++; $display("FAIL abort_on[%0d]: got %h expected 0f", k, bus.o_led_data);
            end
        end
        bus.i_alert_req = 1'b1;
        tick();
        n_chk++;
        if (bus.o_led_data !== 8'h81 || bus.o_busy !== 1'b1) begin
            n_fail++; $display("FAIL abort_enter: got led %h busy %b expected 81 1", bus.o_led_data, bus.o_busy);
        end
        bus.i_alert_data = 8'h42;
        for (int k = 6; k < 29; k++) begin
            tick();
            got_done |= bus.o_evt_done;
            exp = k <= 16 ? 8'h42 : 8'h00;
            n_chk++;
            if (bus.o_led_data !== exp || bus.o_busy !== 1'b1) begin
                n_fail++; $display("FAIL abort_alert[%0d]: got led %h busy %b expected %h 1", k, bus.o_led_data, bus.o_busy, exp);
            end
            if (k == 10) bus.i_alert_req = 1'b0;
        end
        tick();
        n_chk++;
        if (bus.o_busy !== 1'b0 || (bus.o_led_data !== 8'h3C && !(DIM && bus.o_led_data === 8'h00))) begin
            n_fail++; $display("FAIL abort_idle: got led %h busy %b expected 3c 0", bus.o_led_data, bus.o_busy);
        end
        repeat (40) begin
            tick();
            got_done |= bus.o_evt_done;
        end
        n_chk++;
        if (got_done !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_done: got %b expected 0", got_done);
        end
    endtask

    task automatic test_simultaneous;
        logic [7:0] exp;
        logic acked = 1'b0;
        bus.i_base_data = 8'h3C; bus.i_alert_data = 8'h99;
        bus.i_evt_data = 8'h0F; bus.i_evt_count = 4'd2;
        bus.i_alert_req = 1'b1; bus.i_evt_req = 1'b1;
        for (int k = 0; k < 4 * PH; k++) begin
            tick();
            acked |= bus.o_evt_ack;
            exp = ((k / PH) % 2 == 0) ? 8'h99 : 8'h00;
            n_chk++;
            if (bus.o_led_data !== exp || bus.o_busy !== 1'b1) begin
                n_fail++; $display("FAIL simul_alert[%0d]: got led %h busy %b expected %h 1", k, bus.o_led_data, bus.o_busy, exp);
            end
            if (k == 2 * PH) bus.i_alert_req = 1'b0;
            if (k == 4 * PH - 1) bus.i_evt_req = 1'b0;
        end
        tick();
        acked |= bus.o_evt_ack;
        n_chk++;
        if (acked !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL simul_no_ack: got ack-seen %b busy %b expected 0 0", acked, bus.o_busy);
        end
    endtask

    task automatic test_zero_count;
        bus.i_base_data = 8'h3C; bus.i_evt_count = 4'd0; bus.i_evt_req = 1'b1;
        tick();
        n_chk++;
        if ({bus.o_evt_ack, bus.o_evt_done, bus.o_busy} !== 3'b110 || (bus.o_led_data !== 8'h3C && !(DIM && bus.o_led_data === 8'h00))) begin
            n_fail++; $display("FAIL zero_count: got ack %b done %b busy %b led %h expected 1 1 0 3c", bus.o_evt_ack, bus.o_evt_done, bus.o_busy, bus.o_led_data);
        end
        bus.i_evt_req = 1'b0;
        tick();
        n_chk++;
        if ({bus.o_evt_ack, bus.o_evt_done, bus.o_busy} !== 3'b000) begin
            n_fail++; $display("FAIL zero_count_after: got %b expected 000", {bus.o_evt_ack, bus.o_evt_done, bus.o_busy});
        end
    endtask

    task automatic test_short_alert;
        logic [7:0] exp;
        bus.i_base_data = 8'h3C; bus.i_alert_data = 8'hC3; bus.i_alert_req = 1'b1;
        tick();
        bus.i_alert_req = 1'b0;
        n_chk++;
        if (bus.o_led_data !== 8'hC3 || bus.o_busy !== 1'b1) begin
            n_fail++; $display("FAIL short_alert_enter: got led %h busy %b expected c3 1", bus.o_led_data, bus.o_busy);
        end
        for (int k = 1; k < 2 * PH; k++) begin
            tick();
            exp = k < PH ? 8'hC3 : 8'h00;
            n_chk++;
            if (bus.o_led_data !== exp || bus.o_busy !== 1'b1) begin
                n_fail++; $display("FAIL short_alert[%0d]: got led %h busy %b expected %h 1", k, bus.o_led_data, bus.o_busy, exp);
            end
        end
        tick();
        n_chk++;
        if (bus.o_busy !== 1'b0 || (bus.o_led_data !== 8'h3C && !(DIM && bus.o_led_data === 8'h00))) begin
            n_fail++; $display("FAIL short_alert_idle: got led %h busy %b expected 3c 0", bus.o_led_data, bus.o_busy);
        end
    endtask

    task automatic test_reset_mid_flash;
        bus.i_base_data = 8'h3C; bus.i_evt_data = 8'h0F; bus.i_evt_count = 4'd5; bus.i_evt_req = 1'b1;
        tick();
        bus.i_evt_req = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.o_led_data, bus.o_evt_ack, bus.o_evt_done, bus.o_busy} !== 11'd0) begin
            n_fail++; $display("FAIL async_reset: got %h expected 000", {bus.o_led_data, bus.o_evt_ack, bus.o_evt_done, bus.o_busy});
        end
        #2 rst = 1'b0;
        tick();
        n_chk++;
        if (bus.o_busy !== 1'b0 || bus.o_evt_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_lost_event: got busy %b done %b expected 0 0", bus.o_busy, bus.o_evt_done);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp;
        bus.i_evt_data = 8'h5A; bus.i_evt_count = 4'd1;
        for (int n = 0; n < 2; n++) begin
            bus.i_evt_req = 1'b1;
            tick();
            bus.i_evt_req = 1'b0;
            n_chk++;
            if (bus.o_evt_ack !== 1'b1 || bus.o_led_data !== 8'h5A) begin
                n_fail++; $display("FAIL b2b_ack[%0d]: got ack %b led %h expected 1 5a", n, bus.o_evt_ack, bus.o_led_data);
            end
            for (int k = 1; k < 2 * PH; k++) begin
                tick();
                exp = k < PH ? 8'h5A : 8'h00;
                n_chk++;
                if (bus.o_led_data !== exp || bus.o_evt_done !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_seq[%0d][%0d]: got led %h done %b expected %h 0", n, k, bus.o_led_data, bus.o_evt_done, exp);
                end
            end
            tick();
            n_chk++;
            if (bus.o_evt_done !== 1'b1 || bus.o_busy !== 1'b0) begin
                n_fail++; $display("FAIL b2b_done[%0d]: got done %b busy %b expected 1 0", n, bus.o_evt_done, bus.o_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_pattern();
        test_event();
        test_abort_by_alert();
        test_simultaneous();
        test_zero_count();
        test_short_alert();
        test_reset_mid_flash();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/led_array_arbiter.md
# led_array_arbiter

Sequencer and arbiter for the 8-bit LED bar. It chooses one of three sources each cycle: the static game-state pattern, a counted event flash, and a pre-emptive alert blink. It owns the blink timing and produces the active-high `led_data` (1 = ON) consumed by the board LED driver, which handles output polarity.

## Interface
- `TICK_DIV`, default 50000: clock cycles per 1 ms tick. Must be ≥ 1.
- `HALF_PERIOD_MS`, default 250: ticks per ON or OFF blink phase. Must be ≥ 1.
- `clk` in 1: system clock, single domain.
- `rst` in 1: reset, asynchronous, active-high.
- `base_data` in 8: background pattern shown when idle.
- `evt_req` in 1: event flash request, level. Sampled only in IDLE.
- `evt_data` in 8: flash pattern. Latched on acceptance.
- `evt_count` in 4: number of ON/OFF flashes. Latched on acceptance.
- `alert_req` in 1: alert request, level. Highest priority.
- `alert_data` in 8: alert pattern. Live, not latched.
- `led_data` out 8: registered LED pattern, 1 = ON.
- `evt_ack` out 1: one-cycle pulse when an event is accepted.
- `evt_done` out 1: one-cycle pulse when an event completes normally.
- `busy` out 1: high in any state other than IDLE.

## Operation
- State machine states: IDLE, EVT_ON, EVT_OFF, ALERT_ON, ALERT_OFF.
- Phase timer: a cycle counter cleared on every state entry. `phase_end` asserts after exactly TICK_DIV*HALF_PERIOD_MS cycles in a phase.
- IDLE:
  - If `alert_req` is high, go to ALERT_ON. Alert wins over a simultaneous `evt_req`, and no `evt_ack` is given.
  - Else if `evt_req` is high and `evt_count` ≠ 0: pulse `evt_ack`, latch data and count into `remaining`, and go to EVT_ON.
  - Else if `evt_req` is high and `evt_count` = 0: pulse `evt_ack` and `evt_done` in the same cycle and stay in IDLE.
- EVT_ON:
  - `alert_req` goes to ALERT_ON. This aborts the event: `remaining` is discarded and `evt_done` is never pulsed.
  - `phase_end` goes to EVT_OFF.
- EVT_OFF:
  - `alert_req` goes to ALERT_ON, aborting the event as above.
  - On `phase_end` with `remaining` = 1: pulse `evt_done` and go to IDLE.
  - On `phase_end` otherwise: decrement `remaining` and go to EVT_ON.
- ALERT_ON: `phase_end` goes to ALERT_OFF. Deasserting `alert_req` mid-phase does not shorten the phase, so at least one full blink is always shown.
- ALERT_OFF: on `phase_end`, go to ALERT_ON if `alert_req` is still high, else go to IDLE.
- `evt_req` outside IDLE is ignored with no ack. The requester holds the request until it sees `evt_ack`.
- `led_data` value by state:
  - IDLE: `base_data`.
  - EVT_ON: latched `evt_data`.
  - ALERT_ON: `alert_data`.
  - EVT_OFF and ALERT_OFF: 8'h00.

## Timing
- Reset values: `led_data` = 8'h00, `evt_ack` = 0, `evt_done` = 0, `busy` = 0, state = IDLE, all counters 0.
- Asynchronous assert. Reset mid-flash returns to IDLE immediately and loses the pending event without `evt_done`.
- `led_data` latency is one cycle: it reflects the state and inputs sampled at the previous edge.
- `evt_ack` and `busy` rise on the same edge that enters EVT_ON.
- `evt_done` pulses on the edge that returns to IDLE.
- Total event duration is 2*`evt_count`*TICK_DIV*HALF_PERIOD_MS cycles, from the `evt_ack` edge to the `evt_done` edge.
- Counter widths: the cycle counter is sized for TICK_DIV*HALF_PERIOD_MS-1 and must not wrap inside a phase. `remaining` is 4 bits, so the maximum is 15 flashes.

## Configuration
- `LED_ARB_BASE_DIM_EN`
  - Defined: in IDLE, `base_data` is PWM-dimmed to 25% duty. `led_data` = `base_data` only when bits [1:0] of a free-running 2-bit counter are 00, else 8'h00. The counter resets to 0.
  - Not defined: IDLE drives `base_data` continuously. Flash and alert phases are identical in both builds.

## Test plan
All scenarios use TICK_DIV=4, HALF_PERIOD_MS=3, giving 12 cycles per phase.
- Reset then idle: `rst` high, then low, with `base_data`=8'hA5 → `led_data`=8'h00 during reset and 8'hA5 one cycle after release; `busy`=0.
- Event of 2 flashes: `evt_data`=8'h0F, `evt_count`=2, `evt_req` pulsed → `evt_ack` one cycle, `led_data` sequence 0F×12, 00×12, 0F×12, 00×12, `evt_done` at cycle 48, then `base_data`.
- Alert pre-empts: alert asserted at cycle 5 of the EVT_ON phase → ALERT_ON next cycle, `led_data`=`alert_data`, no `evt_done` ever; returns to IDLE after `alert_req` drops and the ALERT_OFF phase ends.
- Simultaneous and zero-count requests: `alert_req` and `evt_req` rise in the same cycle → alert is shown and there is no `evt_ack`. `evt_count`=0 → `evt_ack` and `evt_done` pulse in the same cycle and `busy` stays 0.
- Short alert: `alert_req` high for 1 cycle → full blink of 12 ON + 12 OFF cycles, then IDLE.
- Dim build: with `LED_ARB_BASE_DIM_EN` defined and `base_data`=8'hFF in IDLE → `led_data` is FF exactly 1 of every 4 cycles and 00 otherwise.
